// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared constants, funct3 codes and FSM state type for the data-memory responder
// Purpose: constants shared by the data-memory responder, its aligner and the rest of the core.
// Contents: default base address (also the reset PC), RV32I load/store funct3 codes,
//           dmem_state_e FSM states, offset alignment helpers.
package data_memory_responder_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  // Execution starts at the first byte of data/instruction memory.
  localparam logic [31:0] INITIAL_PC        = DEFAULT_BASE_ADDR;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESPOND
  } dmem_state_e;

  // funct3[1:0] encodes the access size for both loads and stores:
  // 00 byte, 01 halfword, 10 word.
  function automatic logic [1:0] natural_offset(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return {offset[1], 1'b0};
      2'b10:   return 2'b00;
      default: return offset;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - request/response bus between datapath and data-memory responder
// Purpose: groups the data-memory request and response signals.
// Ports:   req_valid/req_ready handshake, req_write, req_address, req_write_data, req_funct3;
//          rsp_valid pulse, rsp_read_data, rsp_error.
// Modports: master = datapath side, slave = responder side.
interface data_memory_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_read_data;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_address, req_write_data, req_funct3,
    input  req_ready, rsp_valid, rsp_read_data, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_address, req_write_data, req_funct3,
    output req_ready, rsp_valid, rsp_read_data, rsp_error
  );

endinterface

// File: rtl/data_memory_responder_load_store_aligner.sv
// rtl/data_memory_responder_load_store_aligner.sv - combinational byte-lane steering for loads and stores
// Purpose: derives store byte enables and lane-replicated store data, extracts and extends
//          load data from a RAM word, and flags unsupported funct3 codes.
// Ports:   funct3, is_write, byte_offset (address[1:0]), store_data, read_word in;
//          byte_enable, lane_store_data, load_data, size_legal out.
module load_store_aligner
  import data_memory_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_write,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_enable,
  output logic [31:0] lane_store_data,
  output logic [31:0] load_data,
  output logic        size_legal
);

  logic [31:0] shifted;

  always_comb begin
    shifted         = read_word >> {byte_offset, 3'b000};
    byte_enable     = 4'b0000;
    lane_store_data = 32'h0;
    load_data       = 32'h0;
    size_legal      = 1'b0;

    if (is_write) begin
      case (funct3)
        FUNCT3_SB: begin
          byte_enable     = 4'b0001 << byte_offset;
          lane_store_data = {4{store_data[7:0]}};
          size_legal      = 1'b1;
        end
        FUNCT3_SH: begin
          byte_enable     = 4'b0011 << byte_offset;
          lane_store_data = {2{store_data[15:0]}};
          size_legal      = 1'b1;
        end
        FUNCT3_SW: begin
          byte_enable     = 4'b1111;
          lane_store_data = store_data;
          size_legal      = 1'b1;
        end
        default: ;
      endcase
    end else begin
      size_legal = 1'b1;
      case (funct3)
        FUNCT3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
        FUNCT3_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
        FUNCT3_LW:  load_data = shifted;
        FUNCT3_LBU: load_data = {24'h0, shifted[7:0]};
        FUNCT3_LHU: load_data = {16'h0, shifted[15:0]};
        default:    size_legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - multi-cycle data-memory responder with word-organised RAM
// Purpose: accepts one load/store at a time, waits WAIT_STATES cycles, performs the access
//          and returns a one-cycle registered response.
// Ports:   clock, reset (synchronous, active-high); bus (data_memory_responder_if.slave).
// Params:  DEPTH_WORDS (power of two), WAIT_STATES (0..15), BASE_ADDR (byte address of word 0).
// Config:  RVSIMPLE_DMEM_MISALIGN_ERR_EN defined -> misaligned halfword/word accesses are errors;
//          undefined -> low address bits are forced to natural alignment.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                  clock,
  input  logic                  reset,
  data_memory_responder_if.slave bus
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam int          ADDR_W = IDX_W + 2;
  localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);

  dmem_state_e state;
  logic [3:0]  wait_cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  funct3_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        rsp_error_q;
  logic [31:0] rsp_data_q;

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [1:0]       raw_lo;
  logic [1:0]       eff_lo;
  logic             misaligned;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      read_word;
  logic [3:0]       byte_enable;
  logic [31:0]      lane_store_data;
  logic [31:0]      load_data;
  logic             size_legal;
  logic             access_error;
  logic             ram_we;

  always_comb begin
    offset   = addr_q - BASE_ADDR;
    raw_lo   = offset[1:0];
    in_range = offset < SPAN;
    word_idx = offset[ADDR_W-1:2];
`ifdef RVSIMPLE_DMEM_MISALIGN_ERR_EN
    misaligned = is_misaligned(funct3_q, raw_lo);
    eff_lo     = raw_lo;
`else
    misaligned = 1'b0;
    eff_lo     = natural_offset(funct3_q, raw_lo);
`endif
    read_word    = ram[word_idx];
    access_error = !size_legal || !in_range || misaligned;
    // Reset during ACCESS must suppress the commit.
    ram_we       = (state == ACCESS) && write_q && !access_error && !reset;
  end

  load_store_aligner u_aligner (
    .funct3          (funct3_q),
    .is_write        (write_q),
    .byte_offset     (eff_lo),
    .store_data      (data_q),
    .read_word       (read_word),
    .byte_enable     (byte_enable),
    .lane_store_data (lane_store_data),
    .load_data       (load_data),
    .size_legal      (size_legal)
  );

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enable[b]) begin
          ram[word_idx][8*b +: 8] <= lane_store_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      funct3_q    <= 3'b000;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q  <= bus.req_write;
            addr_q   <= bus.req_address;
            data_q   <= bus.req_write_data;
            funct3_q <= bus.req_funct3;
            wait_cnt <= 4'(WAIT_STATES);
            ready_q  <= 1'b0;
            state    <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_error_q <= access_error;
          rsp_data_q  <= (access_error || write_q) ? 32'h0 : load_data;
          state       <= RESPOND;
        end
        RESPOND: begin
          rsp_valid_q <= 1'b0;
          rsp_error_q <= 1'b0;
          ready_q     <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with reset keeps req_ready low for the whole reset window while the
  // registered flag is already 1 for the first cycle after release.
  assign bus.req_ready     = ready_q && !reset;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_error     = rsp_error_q;
  assign bus.rsp_read_data = rsp_data_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed self-checking bench for data_memory_responder
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  data_memory_responder_if bus0 ();
  data_memory_responder_if bus1 ();

  data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h8000_0000)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h8000_0000)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er,
                        output int lat);
    @(negedge clock);
    bus0.req_valid      = 1'b1;
    bus0.req_write      = w;
    bus0.req_address    = a;
    bus0.req_write_data = d;
    bus0.req_funct3     = f3;
    @(posedge clock);
    @(negedge clock);
    bus0.req_valid = 1'b0;
    lat = 0;
    rd  = 32'hBAD0_BAD0;
    er  = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (bus0.rsp_valid) begin
        lat = n;
        rd  = bus0.rsp_read_data;
        er  = bus0.rsp_error;
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL rsp_timeout: no rsp_valid for addr %h within 20 cycles", a);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks += 4;
    if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus0.req_ready); end
    if (bus0.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus0.rsp_valid); end
    if (bus0.rsp_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus0.rsp_error); end
    if (bus0.rsp_read_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus0.rsp_read_data); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", bus0.req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, FUNCT3_SW, rd, er, lat);
    checks += 3;
    if (lat != 3) begin errors++; $display("FAIL sw_latency: got %0d expected 3", lat); end
    if (er !== 1'b0) begin errors++; $display("FAIL sw_error: got %b expected 0", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL sw_data: got %h expected 00000000", rd); end
    do_req(1'b0, 32'h8000_0010, 32'h0, FUNCT3_LW, rd, er, lat);
    checks += 2;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
    if (lat != 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", lat); end
    repeat (2) @(negedge clock);
    checks += 3;
    if (bus0.rsp_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL data_hold: got %h expected deadbeef", bus0.rsp_read_data); end
    if (bus0.rsp_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", bus0.rsp_valid); end
    if (bus0.rsp_error !== 1'b0) begin errors++; $display("FAIL error_idle: got %b expected 0", bus0.rsp_error); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h8000_0011, 32'h1234_5680, FUNCT3_SB, rd, er, lat);
    do_req(1'b0, 32'h8000_0011, 32'h0, FUNCT3_LB, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", rd); end
    do_req(1'b0, 32'h8000_0011, 32'h0, FUNCT3_LBU, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", rd); end
    do_req(1'b0, 32'h8000_0010, 32'h0, FUNCT3_LW, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_80EF) begin errors++; $display("FAIL sb_merge: got %h expected dead80ef", rd); end
  endtask

  task automatic test_halfword();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h8000_0014, 32'h1111_1111, FUNCT3_SW, rd, er, lat);
    do_req(1'b1, 32'h8000_0016, 32'hAAAA_8765, FUNCT3_SH, rd, er, lat);
    do_req(1'b0, 32'h8000_0014, 32'h0, FUNCT3_LW, rd, er, lat);
    checks++;
    if (rd !== 32'h8765_1111) begin errors++; $display("FAIL sh_merge: got %h expected 87651111", rd); end
    do_req(1'b0, 32'h8000_0016, 32'h0, FUNCT3_LH, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_8765) begin errors++; $display("FAIL lh_data: got %h expected ffff8765", rd); end
    do_req(1'b0, 32'h8000_0016, 32'h0, FUNCT3_LHU, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_8765) begin errors++; $display("FAIL lhu_data: got %h expected 00008765", rd); end
    do_req(1'b0, 32'h8000_0014, 32'h0, FUNCT3_LB, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_0011) begin errors++; $display("FAIL lb_pos: got %h expected 00000011", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h7FFF_FFFC, 32'h0, FUNCT3_LW, rd, er, lat);
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL below_base_err: got %b expected 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL below_base_data: got %h expected 0", rd); end
    do_req(1'b0, 32'h8000_1000, 32'h0, FUNCT3_LW, rd, er, lat);
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL above_top_err: got %b expected 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL above_top_data: got %h expected 0", rd); end
    do_req(1'b0, 32'h8000_0FFC, 32'h0, FUNCT3_LW, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL last_word_err: got %b expected 0", er); end
    do_req(1'b0, 32'h8000_0010, 32'h0, 3'b011, rd, er, lat);
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL funct3_011_err: got %b expected 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL funct3_011_data: got %h expected 0", rd); end
    do_req(1'b1, 32'h8000_0010, 32'h0000_0000, 3'b100, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL store_f3_err: got %b expected 1", er); end
    do_req(1'b1, 32'h8000_1010, 32'hCAFE_BABE, FUNCT3_SW, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL oob_store_err: got %b expected 1", er); end
    do_req(1'b0, 32'h8000_0010, 32'h0, FUNCT3_LW, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_80EF) begin errors++; $display("FAIL ram_unchanged: got %h expected dead80ef", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h8000_0013, 32'h0, FUNCT3_LH, rd, er, lat);
`ifdef RVSIMPLE_DMEM_MISALIGN_ERR_EN
    checks += 2;
    if (er !== 1'b1) begin errors++; $display("FAIL lh_mis_err: got %b expected 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL lh_mis_data: got %h expected 0", rd); end
    do_req(1'b1, 32'h8000_0011, 32'h5555_5555, FUNCT3_SW, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL sw_mis_err: got %b expected 1", er); end
    do_req(1'b0, 32'h8000_0010, 32'h0, FUNCT3_LW, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_80EF) begin errors++; $display("FAIL sw_mis_ram: got %h expected dead80ef", rd); end
`else
    checks += 2;
    if (er !== 1'b0) begin errors++; $display("FAIL lh_align_err: got %b expected 0", er); end
    if (rd !== 32'hFFFF_DEAD) begin errors++; $display("FAIL lh_align_data: got %h expected ffffdead", rd); end
    do_req(1'b1, 32'h8000_0011, 32'h5555_5555, FUNCT3_SW, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL sw_align_err: got %b expected 0", er); end
    do_req(1'b0, 32'h8000_0010, 32'h0, FUNCT3_LW, rd, er, lat);
    checks++;
    if (rd !== 32'h5555_5555) begin errors++; $display("FAIL sw_align_ram: got %h expected 55555555", rd); end
`endif
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int lat;
    logic saw_valid; logic saw_ready;
    do_req(1'b1, 32'h8000_0020, 32'h1122_3344, FUNCT3_SW, rd, er, lat);
    @(negedge clock);
    bus0.req_valid      = 1'b1;
    bus0.req_write      = 1'b1;
    bus0.req_address    = 32'h8000_0020;
    bus0.req_write_data = 32'h1234_5678;
    bus0.req_funct3     = FUNCT3_SW;
    @(posedge clock);
    @(negedge clock);
    bus0.req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    saw_valid = 1'b0;
    saw_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      if (bus0.rsp_valid) saw_valid = 1'b1;
      if (bus0.req_ready) saw_ready = 1'b1;
    end
    reset = 1'b0;
    #1;
    checks += 3;
    if (saw_valid !== 1'b0) begin errors++; $display("FAIL reset_drop_rsp: got %b expected 0", saw_valid); end
    if (saw_ready !== 1'b0) begin errors++; $display("FAIL reset_hold_ready: got %b expected 0", saw_ready); end
    if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus0.req_ready); end
    do_req(1'b0, 32'h8000_0020, 32'h0, FUNCT3_LW, rd, er, lat);
    checks++;
    if (rd !== 32'h1122_3344) begin errors++; $display("FAIL reset_no_commit: got %h expected 11223344", rd); end
  endtask

  task automatic test_back_to_back();
    logic exp_valid; logic exp_ready;
    @(negedge clock);
    bus1.req_valid      = 1'b1;
    bus1.req_write      = 1'b1;
    bus1.req_address    = 32'h8000_0000;
    bus1.req_write_data = 32'hA5A5_A5A5;
    bus1.req_funct3     = FUNCT3_SW;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clock);
      exp_valid = ((n % 3) == 2);
      exp_ready = ((n % 3) == 0);
      checks += 3;
      if (bus1.rsp_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", n, bus1.rsp_valid, exp_valid); end
      if (bus1.req_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", n, bus1.req_ready, exp_ready); end
      if (bus1.rsp_error !== 1'b0) begin errors++; $display("FAIL b2b_error[%0d]: got %b expected 0", n, bus1.rsp_error); end
    end
    bus1.req_valid = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_address = 32'h0;
    bus0.req_write_data = 32'h0; bus0.req_funct3 = 3'b000;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_address = 32'h0;
    bus1.req_write_data = 32'h0; bus1.req_funct3 = 3'b000;
    test_reset();
    test_word();
    test_byte();
    test_halfword();
    test_errors();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
